// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - 8N1 UART receive framer with 2-of-3 mid-bit majority voting
//
// Ports:
//   clk          - single clock, rising edge
//   rst_n        - asynchronous active-low reset
//   uart_rx      - asynchronous serial input, idles high
//   rx_data      - last correctly framed byte
//   rx_valid     - one-cycle pulse, coincident with rx_data update
//   rx_frame_err - one-cycle pulse when the stop bit is sampled low
//   rx_busy      - high whenever the framer is not idle
module uart_rx_framer #(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int BAUD_DIV      = CLK_FREQUENCE / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  generate
    if (BAUD_DIV < 8) begin : g_bad_baud_div
      $error("uart_rx_framer: BAUD_DIV must be at least 8");
    end
  endgenerate

  localparam int MID   = BAUD_DIV / 2;
  localparam int CNT_W = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] CNT_SAMP_A = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP_B = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             samp_a;
  logic             samp_b;

  logic fall;
  logic at_decide;
  logic at_wrap;
  logic decision;

  assign fall      = rx_prev & ~rx_s2;
  assign at_decide = (cnt == CNT_DECIDE);
  assign at_wrap   = (cnt == CNT_LAST);
  // Third sample is the live synchronized value at the decision point.
  assign decision  = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);

  // Synchronizer chain; reset to the idle-line level so no false edge
  // is seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shreg        <= 8'h00;
      samp_a       <= 1'b1;
      samp_b       <= 1'b1;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;

      if (state != IDLE && state != WAIT_HIGH) begin
        if (cnt == CNT_SAMP_A) samp_a <= rx_s2;
        if (cnt == CNT_SAMP_B) samp_b <= rx_s2;
        cnt <= at_wrap ? '0 : cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state   <= START;
            bit_idx <= 3'd0;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          // A start bit that votes high was a glitch: drop it silently.
          if (at_decide && decision) begin
            state   <= IDLE;
            cnt     <= '0;
            rx_busy <= 1'b0;
          end else if (at_wrap) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (at_decide) shreg <= {decision, shreg[7:1]};
          if (at_wrap) begin
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= 3'd0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          // Leave at mid-stop-bit so a back-to-back start edge is caught.
          if (at_decide) begin
            cnt <= '0;
            if (decision) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
              rx_busy  <= 1'b0;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s2) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - self-checking bench for uart_rx_framer
module tb_uart_rx_framer;

  localparam int CLK_F = 50_000_000;
  localparam int BAUD  = 5_000_000;
  localparam int BD    = CLK_F / BAUD;
  localparam int MID   = BD / 2;
  localparam int LAT   = 3 + 9 * BD + MID + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         err_cnt = 0;
  int         proto_viol = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  int         last_fall = 0;
  logic [7:0] model_data = 8'h00;

  uart_rx_framer #(
    .CLK_FREQUENCE(CLK_F),
    .BAUD_RATE    (BAUD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cycle++;

  // Output monitor: records every pulse and any pulse-shape violation.
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      got_cyc.push_back(cycle);
    end
    if (rx_frame_err) err_cnt++;
    if (rx_valid && rx_frame_err) proto_viol++;
    if ((rx_valid && prev_valid) || (rx_frame_err && prev_err)) proto_viol++;
    prev_valid = rx_valid;
    prev_err   = rx_frame_err;
  end

  task automatic hold(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    err_cnt = 0;
  endtask

  // Serial 8N1 frame, LSB first; optional one-cycle inversion mid-bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
    last_fall = cycle;
    hold(1'b0, BD);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        hold(b[i], MID);
        hold(~b[i], 1);
        hold(b[i], BD - MID - 1);
      end else begin
        hold(b[i], BD);
      end
    end
    hold(stop, BD);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rx_frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    rst_n = 1'b1;
    hold(1'b1, 5);
  endtask

  task automatic test_single();
    int lat;
    clear_obs();
    send_frame(8'hEC, 1'b1, -1);
    hold(1'b1, 2 * BD);
    model_data = 8'hEC;
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'hEC) begin errors++; $display("FAIL single_data got %h want ec", got_q[0]); end
      lat = got_cyc[0] - last_fall;
      checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
        errors++; $display("FAIL single_latency got %0d want %0d+-1", lat, LAT);
      end
    end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL single_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'hBA, 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
    hold(1'b1, 2 * BD);
    model_data = 8'h55;
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== 8'hBA) begin errors++; $display("FAIL b2b_first got %h want ba", got_q[0]); end
      checks++; if (got_q[1] !== 8'h55) begin errors++; $display("FAIL b2b_second got %h want 55", got_q[1]); end
    end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL b2b_err got %0d want 0", err_cnt); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", rx_busy); end
  endtask

  task automatic test_start_glitch();
    int idle_at;
    clear_obs();
    hold(1'b0, 3);
    uart_rx = 1'b1;
    idle_at = -1;
    for (int i = 0; i < BD && idle_at < 0; i++) begin
      @(negedge clk);
      if (rx_busy === 1'b0) idle_at = i;
    end
    checks++; if (idle_at < 0) begin errors++; $display("FAIL glitch_busy_clear got busy=%b after %0d cycles want 0", rx_busy, BD); end
    hold(1'b1, 2 * BD);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", got_q.size()); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL glitch_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_frame_error();
    send_frame(8'hEC, 1'b1, -1);
    hold(1'b1, BD);
    model_data = 8'hEC;
    clear_obs();
    send_frame(8'h00, 1'b0, -1);
    hold(1'b0, 3 * BD);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", err_cnt); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", got_q.size()); end
    checks++; if (rx_data !== model_data) begin errors++; $display("FAIL ferr_hold_data got %h want %h", rx_data, model_data); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low_line got %b want 1", rx_busy); end
    hold(1'b1, BD);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", rx_busy); end
    send_frame(8'hA5, 1'b1, -1);
    hold(1'b1, 2 * BD);
    model_data = 8'hA5;
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ferr_next_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL ferr_next_data got %h want a5", got_q[0]); end
    end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL ferr_single_pulse got %0d want 1", err_cnt); end
  endtask

  task automatic test_majority();
    clear_obs();
    send_frame(8'h0F, 1'b1, 3);
    hold(1'b1, 2 * BD);
    model_data = 8'h0F;
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL vote_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'h0F) begin errors++; $display("FAIL vote_data got %h want 0f", got_q[0]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h3C;
    clear_obs();
    hold(1'b0, BD);
    for (int i = 0; i < 4; i++) hold(b[i], BD);
    hold(b[4], MID);
    rst_n = 1'b0;
    #1;
    model_data = 8'h00;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", rx_busy); end
    hold(1'b1, 3);
    rst_n = 1'b1;
    hold(1'b1, 2 * BD);
    checks++; if (got_q.size() !== 0 || err_cnt !== 0) begin
      errors++; $display("FAIL rstmid_no_pulse got valid=%0d err=%0d want 0 0", got_q.size(), err_cnt);
    end
    send_frame(8'h3C, 1'b1, -1);
    hold(1'b1, 2 * BD);
    model_data = 8'h3C;
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rstmid_next_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'h3C) begin errors++; $display("FAIL rstmid_next_data got %h want 3c", got_q[0]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_err;
    logic [7:0] b;
    logic       stop;
    exp_err = 0;
    clear_obs();
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1);
      if (stop) begin
        exp_q.push_back(b);
        model_data = b;
        if ($urandom_range(0, 1) == 1) hold(1'b1, $urandom_range(1, 2 * BD));
      end else begin
        exp_err++;
        if ($urandom_range(0, 1) == 1) hold(1'b0, $urandom_range(1, BD));
        hold(1'b1, $urandom_range(1, 2) * BD);
      end
    end
    hold(1'b1, 2 * BD);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL rand_err got %0d want %0d", err_cnt, exp_err); end
    checks++; if (rx_data !== model_data) begin errors++; $display("FAIL rand_final_data got %h want %h", rx_data, model_data); end
  endtask

  task automatic test_protocol();
    checks++; if (proto_viol !== 0) begin errors++; $display("FAIL pulse_shape got %0d violations want 0", proto_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_start_glitch();
    test_frame_error();
    test_majority();
    test_reset_midframe();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
